// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and baud helper for the UART blocks
package uart_pkg;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Bit counter must reach the widest field, nine data bits
    localparam int BIT_CNT_W = $clog2(9 + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // Clock cycles per bit, truncated
    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter shared by the UART transmitter and receiver
//
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset, clears the count
//   restart - forces the count to 0 so the next bit period starts fresh
//   bit_end - high on the last cycle of each DIV-cycle bit period
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with internal baud divider and valid/ready input
//
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset; abandons any frame in progress
//   valid   - upstream offers data; accepted on an edge where ready is high
//   data    - payload, sent LSB first
//   ready   - transmitter idle and able to accept
//   tx_done - one-cycle pulse once the last stop bit has completed
//   tx      - serial line, idle high, driven from a flop
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    // Holding the counter cleared while idle makes every frame's bit
    // periods line up with its accept edge.
    uart_baud_cnt #(
        .DIV(BAUD_DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(state_q == S_IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    // tx_d is the value the line takes after this edge, so each bit is
    // presented on the same edge that ends the previous one.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        tx_d     = tx_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d  = S_START;
                    shreg_d  = data;
                    par_d    = (PARITY == PAR_ODD) ? ~^data : ^data;
                    bitcnt_d = '0;
                    tx_d     = 1'b0;
                    ready_d  = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bitcnt_q == LAST_DATA) begin
                        bitcnt_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = S_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        shreg_d  = shreg_q >> 1;
                        tx_d     = shreg_q[1];
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d  = S_STOP;
                    bitcnt_d = '0;
                    tx_d     = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bitcnt_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    assign tx      = tx_q;
    assign ready   = ready_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - randomized self-checking bench for uart_tx_cfg in 8N1, 8E1, 8O1 and 7N2 builds
module tb_uart_tx_cfg;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] valid_v;
    logic [7:0] data;
    logic [3:0] tx_v;
    logic [3:0] ready_v;
    logic [3:0] done_v;

    int dbits [4] = '{8, 8, 8, 7};
    int pmode [4] = '{0, 2, 1, 0};
    int stops [4] = '{1, 1, 1, 2};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .valid(valid_v[0]), .data(data),
        .ready(ready_v[0]), .tx_done(done_v[0]), .tx(tx_v[0]));
    uart_tx_cfg #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .valid(valid_v[1]), .data(data),
        .ready(ready_v[1]), .tx_done(done_v[1]), .tx(tx_v[1]));
    uart_tx_cfg #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .valid(valid_v[2]), .data(data),
        .ready(ready_v[2]), .tx_done(done_v[2]), .tx(tx_v[2]));
    uart_tx_cfg #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .valid(valid_v[3]), .data(data[6:0]),
        .ready(ready_v[3]), .tx_done(done_v[3]), .tx(tx_v[3]));

    task automatic check_val(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int frame_len(input int idx);
        return 1 + dbits[idx] + ((pmode[idx] != 0) ? 1 : 0) + stops[idx];
    endfunction

    // Line level for bit slot k of a frame carrying d
    function automatic logic exp_bit(input int idx, input int d, input int k);
        int ones;
        int db;
        ones = 0;
        db = dbits[idx];
        if (k == 0) return 1'b0;
        if (k <= db) return ((d >> (k - 1)) & 1) == 1;
        if (pmode[idx] != 0 && k == db + 1) begin
            for (int i = 0; i < db; i++) ones += (d >> i) & 1;
            if (pmode[idx] == 2) return (ones % 2) == 1;
            return (ones % 2) == 0;
        end
        return 1'b1;
    endfunction

    task automatic idle_check(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                check_val($sformatf("idle_tx[%0d]", i), tx_v[i], 1'b1);
                check_val($sformatf("idle_ready[%0d]", i), ready_v[i], 1'b1);
                check_val($sformatf("idle_done[%0d]", i), done_v[i], 1'b0);
            end
        end
    endtask

    // Entered at a negedge. keep leaves valid high with nd offered next;
    // rst_at >= 0 fires reset on edge E0+rst_at.
    task automatic frame(input int idx, input int d, input bit keep, input int nd, input int rst_at);
        int n;
        n = frame_len(idx) * DIV;
        valid_v[idx] = 1'b1;
        data = d[7:0];
        check_val($sformatf("ready_pre[%0d]", idx), ready_v[idx], 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (keep) data = nd[7:0];
        else valid_v[idx] = 1'b0;
        for (int t = 0; t <= n; t++) begin
            if (t == rst_at) begin
                check_val($sformatf("rst_tx[%0d]", idx), tx_v[idx], 1'b1);
                check_val($sformatf("rst_ready[%0d]", idx), ready_v[idx], 1'b1);
                check_val($sformatf("rst_done[%0d]", idx), done_v[idx], 1'b0);
                rst = 1'b0;
                return;
            end
            if (t < n) begin
                check_val($sformatf("tx[%0d] d=%0h t=%0d", idx, d, t), tx_v[idx], exp_bit(idx, d, t / DIV));
                check_val($sformatf("busy_ready[%0d] t=%0d", idx, t), ready_v[idx], 1'b0);
                check_val($sformatf("busy_done[%0d] t=%0d", idx, t), done_v[idx], 1'b0);
            end else begin
                check_val($sformatf("end_tx[%0d]", idx), tx_v[idx], 1'b1);
                check_val($sformatf("end_ready[%0d]", idx), ready_v[idx], 1'b1);
                check_val($sformatf("end_done[%0d]", idx), done_v[idx], 1'b1);
            end
            if (!keep && t == 25) begin
                valid_v[idx] = 1'b1;
                data = 8'($urandom);
            end
            if (!keep && t == 26) begin
                valid_v[idx] = 1'b0;
                data = d[7:0];
            end
            if (t + 1 == rst_at) rst = 1'b1;
            if (t < n) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_v = '0;
        data = '0;
        idle_check(3);
        rst = 1'b0;
        idle_check(3);
        rst = 1'b1;
        idle_check(3);
        rst = 1'b0;
        idle_check(2);

        frame(0, 'hA5, 1'b0, 0, -1);
        idle_check(1);
        frame(1, 'h07, 1'b0, 0, -1);
        idle_check(1);
        frame(2, 'h07, 1'b0, 0, -1);
        idle_check(1);
        frame(3, 'h55, 1'b0, 0, -1);
        idle_check(1);

        frame(0, 'h01, 1'b1, 'h02, -1);
        frame(0, 'h02, 1'b0, 0, -1);
        idle_check(1);

        frame(0, int'($urandom_range(0, 255)), 1'b0, 0, 40);
        idle_check(4);
        frame(0, 'h3C, 1'b0, 0, -1);
        idle_check(1);

        rst = 1'b1;
        valid_v[0] = 1'b1;
        data = 8'($urandom);
        @(negedge clk);
        check_val("rst_valid_ready", ready_v[0], 1'b1);
        check_val("rst_valid_tx", tx_v[0], 1'b1);
        rst = 1'b0;
        valid_v[0] = 1'b0;
        idle_check(2);

        for (int r = 0; r < 12; r++) begin
            frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b0, 0, -1);
            idle_check(int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
